button_conditioner: RTL

- Front-end stage that turns the three raw board pushbuttons (start, progressive, regressive) into clean, single-cycle command pulses.
- Its outputs feed the colour-sequencing state machine directly.
- Per-button work: synchronises each raw input, debounces press and release, and emits exactly one pulse per accepted press.
- Arbitrates same-cycle presses so the consumer never sees two commands at once.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: per-button two-flop synchroniser, press/release debounce FSM,
// and one prioritised single-cycle command pulse per accepted press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_prog,
  input  logic       btn_reg,
  output logic       start,
  output logic       progressive,
  output logic       regressive,
  output logic [2:0] btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] press_evt;
  logic [2:0] level_nxt;

  // Channel index order matches btn_level: 0 = start, 1 = progressive, 2 = regressive.
  assign raw = {btn_reg, btn_prog, btn_start};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             evt;

    // NOTE: the reset branch clears every flop asynchronously, so a reset
    // mid-pulse or mid-debounce always lands the channel back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // NOTE: every output of this block is defaulted before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      evt       = 1'b0;
      case (state)
        IDLE: begin
          if (sync2[g]) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[g]) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            evt       = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2[g]) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          // Counter stops at CNT_LAST; it never wraps back to zero while waiting.
          if (sync2[g]) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign press_evt[g] = evt;
    assign level_nxt[g] = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  // Same-edge presses: start wins over progressive over regressive; losers are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start       <= 1'b0;
      progressive <= 1'b0;
      regressive  <= 1'b0;
      btn_level   <= '0;
    end else begin
      start       <= press_evt[0];
      progressive <= press_evt[1] & ~press_evt[0];
      regressive  <= press_evt[2] & ~press_evt[1] & ~press_evt[0];
      btn_level   <= level_nxt;
    end
  end

endmodule
